// File: rtl/ceespu_memory_stage_pkg.sv
// Shared encodings for the ceespu memory stage: load size selects, writeback
// source selects, controller states and the writeback source mux.
package ceespu_mem_pkg;

    localparam logic [1:0] SELMEM_WORD = 2'd0;
    localparam logic [1:0] SELMEM_HALF = 2'd1;
    localparam logic [1:0] SELMEM_BYTE = 2'd2;

    localparam logic [1:0] SELWB_ALU  = 2'd0;
    localparam logic [1:0] SELWB_LOAD = 2'd1;
    localparam logic [1:0] SELWB_LINK = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_e;

    // Select code 3 aliases the ALU result, like code 0.
    function automatic logic [31:0] wb_select(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] load,
        input logic [13:0] pc
    );
        logic [31:0] res;
        case (sel)
            SELWB_LOAD: res = load;
            SELWB_LINK: res = {18'b0, pc};
            default:    res = alu;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ceespu_load_align.sv
// Combinational load aligner: picks the byte/half/word field out of the bus
// word using the low address bits and sign- or zero-extends it to 32 bits.
module ceespu_load_align
    import ceespu_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  sel_mem_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        signed_s;

    assign signed_s = ~sel_mem_i[2];
    // addr[0] picks the upper half, matching the execute-stage halfword lane enables.
    assign half_s   = addr_i[0] ? rdata_i[31:16] : rdata_i[15:0];

    // Byte lane selection by address offset.
    always_comb begin
        byte_s = 8'h00;
        case (addr_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Size selection and extension.
    always_comb begin
        data_o = rdata_i;
        case (sel_mem_i[1:0])
            SELMEM_BYTE: data_o = {{24{signed_s & byte_s[7]}}, byte_s};
            SELMEM_HALF: data_o = {{16{signed_s & half_s[15]}}, half_s};
            SELMEM_WORD: data_o = rdata_i;
            default:     data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ceespu_memory_stage.sv
// ceespu memory stage: IDLE/REQ bus handshake, load alignment and registered
// writeback. Optional bus timeout is enabled by defining CEESPU_MEM_TIMEOUT_EN.
module ceespu_memory_stage
    import ceespu_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_aluResult,
    input  logic [31:0] I_memAddress,
    input  logic [31:0] I_storeData,
    input  logic [3:0]  I_memWe,
    input  logic        I_memE,
    input  logic [2:0]  I_selMem,
    input  logic [1:0]  I_selWb,
    input  logic        I_we,
    input  logic [4:0]  I_regD,
    input  logic [13:0] I_PC,
    output logic        O_busReq,
    output logic [31:0] O_busAddr,
    output logic [31:0] O_busWdata,
    output logic [3:0]  O_busWe,
    input  logic        I_busAck,
    input  logic [31:0] I_busRdata,
    output logic        O_stall,
    output logic        O_we,
    output logic [4:0]  O_regD,
    output logic [31:0] O_wbData,
    output logic        O_busError
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_we_q, bus_we_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  sel_mem_q, sel_mem_d;
    logic [1:0]  sel_wb_q, sel_wb_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [13:0] pc_q, pc_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] load_data_s;
    logic        timeout_s;
    logic        stall_s;

    ceespu_load_align u_align (
        .rdata_i   (I_busRdata),
        .addr_i    (addr_lo_q),
        .sel_mem_i (sel_mem_q),
        .data_o    (load_data_s)
    );

`ifdef CEESPU_MEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_s = (state_q == REQ) && !I_busAck &&
                       (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Counts unacknowledged REQ cycles; cleared on every REQ entry.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (!I_busAck) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Timeout counter register.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Handshake controller, field latching and writeback selection.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        addr_lo_d   = addr_lo_q;
        sel_mem_d   = sel_mem_q;
        sel_wb_d    = sel_wb_q;
        rd_d        = rd_q;
        we_d        = we_q;
        pc_d        = pc_q;
        alu_d       = alu_q;
        stall_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_memE) begin
                    stall_s     = 1'b1;
                    state_d     = REQ;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = {I_memAddress[31:2], 2'b00};
                    bus_wdata_d = I_storeData;
                    bus_we_d    = I_memWe;
                    addr_lo_d   = I_memAddress[1:0];
                    sel_mem_d   = I_selMem;
                    sel_wb_d    = I_selWb;
                    rd_d        = I_regD;
                    we_d        = I_we;
                    pc_d        = I_PC;
                    alu_d       = I_aluResult;
                end else begin
                    wb_we_d   = I_we;
                    wb_rd_d   = I_regD;
                    wb_data_d = wb_select(I_selWb, I_aluResult, I_aluResult, I_PC);
                end
            end
            REQ: begin
                if (I_busAck) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    wb_we_d   = we_q;
                    wb_rd_d   = rd_q;
                    wb_data_d = wb_select(sel_wb_q, alu_q, load_data_s, pc_q);
                end else if (timeout_s) begin
                    // Abandoned access: release the pipeline with no writeback.
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State, bus and writeback registers.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_we_q    <= 4'h0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0000_0000;
            addr_lo_q   <= 2'd0;
            sel_mem_q   <= 3'd0;
            sel_wb_q    <= 2'd0;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            pc_q        <= 14'd0;
            alu_q       <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            addr_lo_q   <= addr_lo_d;
            sel_mem_q   <= sel_mem_d;
            sel_wb_q    <= sel_wb_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
        end
    end

    assign O_busReq   = bus_req_q;
    assign O_busAddr  = bus_addr_q;
    assign O_busWdata = bus_wdata_q;
    assign O_busWe    = bus_we_q;
    assign O_we       = wb_we_q;
    assign O_regD     = wb_rd_q;
    assign O_wbData   = wb_data_q;
    assign O_stall    = stall_s;
    assign O_busError = timeout_s;

endmodule

// File: tb/tb_ceespu_memory_stage.sv
// Self-checking bench for ceespu_memory_stage: vector table, writeback
// scoreboard, and hand-written reset / long-wait / timeout sequences.
module tb_ceespu_memory_stage;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [31:0] I_aluResult, I_memAddress, I_storeData, I_busRdata;
    logic [3:0]  I_memWe;
    logic        I_memE, I_we, I_busAck;
    logic [2:0]  I_selMem;
    logic [1:0]  I_selWb;
    logic [4:0]  I_regD;
    logic [13:0] I_PC;
    logic        O_busReq, O_stall, O_we, O_busError;
    logic [31:0] O_busAddr, O_busWdata, O_wbData;
    logic [3:0]  O_busWe;
    logic [4:0]  O_regD;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic        memE;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [3:0]  memwe;
        logic [2:0]  selmem;
        logic [1:0]  selwb;
        logic [13:0] pc;
        int          ackdly;
        logic [31:0] rdata;
        logic [31:0] expdata;
    } vec_t;

    wb_t  exp_q[$];
    vec_t vecs[12];

    always #5 I_clk = ~I_clk;

    ceespu_memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_aluResult  (I_aluResult),
        .I_memAddress (I_memAddress),
        .I_storeData  (I_storeData),
        .I_memWe      (I_memWe),
        .I_memE       (I_memE),
        .I_selMem     (I_selMem),
        .I_selWb      (I_selWb),
        .I_we         (I_we),
        .I_regD       (I_regD),
        .I_PC         (I_PC),
        .O_busReq     (O_busReq),
        .O_busAddr    (O_busAddr),
        .O_busWdata   (O_busWdata),
        .O_busWe      (O_busWe),
        .I_busAck     (I_busAck),
        .I_busRdata   (I_busRdata),
        .O_stall      (O_stall),
        .O_we         (O_we),
        .O_regD       (O_regD),
        .O_wbData     (O_wbData),
        .O_busError   (O_busError)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        I_memE = 1'b0; I_we = 1'b0; I_busAck = 1'b0; I_memWe = 4'h0;
        I_aluResult = 32'h0; I_memAddress = 32'h0; I_storeData = 32'h0;
        I_selMem = 3'd0; I_selWb = 2'd0; I_regD = 5'd0; I_PC = 14'd0;
        I_busRdata = 32'h0;
    endtask

    task automatic scramble_inputs();
        I_memE = 1'b1; I_we = 1'b1; I_memWe = 4'($urandom);
        I_aluResult = $urandom; I_memAddress = $urandom; I_storeData = $urandom;
        I_selMem = 3'($urandom); I_selWb = 2'($urandom);
        I_regD = 5'($urandom); I_PC = 14'($urandom);
    endtask

    // Drive one instruction at posedge+1; returns at posedge+1 after writeback.
    task automatic run_vec(input vec_t v, input string nm);
        int  stalls;
        wb_t e, got;
        I_memE = v.memE; I_we = v.we; I_regD = v.rd; I_aluResult = v.alu;
        I_memAddress = v.addr; I_storeData = v.sdata; I_memWe = v.memwe;
        I_selMem = v.selmem; I_selWb = v.selwb; I_PC = v.pc;
        I_busAck = 1'b1;
        I_busRdata = $urandom;
        e.we = v.we; e.rd = v.rd; e.data = v.expdata;
        exp_q.push_back(e);
        stalls = 0;
        #1;
        if (O_stall) stalls++;
        @(posedge I_clk); #1;
        if (v.memE) begin
            chk({nm, " bubble_we"}, {31'b0, O_we}, 32'd0);
            for (int k = 0; k <= v.ackdly; k++) begin
                scramble_inputs();
                I_busAck   = (k == v.ackdly);
                I_busRdata = (k == v.ackdly) ? v.rdata : $urandom;
                #1;
                if (O_stall) stalls++;
                chk({nm, " busReq"},   {31'b0, O_busReq}, 32'd1);
                chk({nm, " busAddr"},  O_busAddr, v.addr & 32'hFFFF_FFFC);
                chk({nm, " busWdata"}, O_busWdata, v.sdata);
                chk({nm, " busWe"},    {28'b0, O_busWe}, {28'b0, v.memwe});
                chk({nm, " busError"}, {31'b0, O_busError}, 32'd0);
                if (k > 0) chk({nm, " req_we"}, {31'b0, O_we}, 32'd0);
                @(posedge I_clk); #1;
            end
            chk({nm, " busReq_drop"}, {31'b0, O_busReq}, 32'd0);
        end
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard_empty actual=0 required=1", nm);
        end else begin
            got = exp_q.pop_front();
            chk({nm, " wb_we"},   {31'b0, O_we}, {31'b0, got.we});
            chk({nm, " wb_regD"}, {27'b0, O_regD}, {27'b0, got.rd});
            chk({nm, " wb_data"}, O_wbData, got.data);
        end
        chk({nm, " stall_cycles"}, stalls, v.memE ? v.ackdly + 1 : 0);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;
        //             memE  we    rd     alu            addr           sdata          memwe  selmem  selwb pc        dly rdata          expdata
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'h0000_1234, 32'h0,         32'h0,         4'h0,  3'b000, 2'd0, 14'h0000, 0, 32'h0,         32'h0000_1234};
        vecs[1]  = '{1'b0, 1'b1, 5'd31, 32'h5555_5555, 32'h0,         32'h0,         4'h0,  3'b000, 2'd2, 14'h3ABC, 0, 32'h0,         32'h0000_3ABC};
        vecs[2]  = '{1'b0, 1'b0, 5'd7,  32'hCAFE_F00D, 32'h0,         32'h0,         4'h0,  3'b000, 2'd3, 14'h0001, 0, 32'h0,         32'hCAFE_F00D};
        vecs[3]  = '{1'b1, 1'b1, 5'd3,  32'h0000_0103, 32'h0000_0103, 32'h0,         4'h0,  3'b010, 2'd1, 14'h0010, 2, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[4]  = '{1'b1, 1'b1, 5'd4,  32'h0000_0201, 32'h0000_0201, 32'h0,         4'h0,  3'b101, 2'd1, 14'h0011, 0, 32'hBEEF_1234, 32'h0000_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0400, 32'h0000_0400, 32'hDEAD_BEEF, 4'hF,  3'b000, 2'd0, 14'h0012, 3, 32'h1111_1111, 32'h0000_0400};
        vecs[6]  = '{1'b1, 1'b1, 5'd9,  32'h0000_0012, 32'h0000_0012, 32'h0,         4'h0,  3'b001, 2'd1, 14'h0013, 1, 32'h1234_8001, 32'hFFFF_8001};
        vecs[7]  = '{1'b1, 1'b1, 5'd10, 32'h0000_0021, 32'h0000_0021, 32'h0,         4'h0,  3'b110, 2'd1, 14'h0014, 0, 32'h1122_8344, 32'h0000_0083};
        vecs[8]  = '{1'b1, 1'b1, 5'd11, 32'h0000_07FC, 32'h0000_07FC, 32'h0,         4'h0,  3'b000, 2'd1, 14'h0015, 1, 32'h89AB_CDEF, 32'h89AB_CDEF};
        vecs[9]  = '{1'b1, 1'b1, 5'd12, 32'h0000_0040, 32'h0000_0040, 32'h0,         4'h0,  3'b010, 2'd1, 14'h0016, 0, 32'hFFFF_FF7F, 32'h0000_007F};
        vecs[10] = '{1'b1, 1'b1, 5'd1,  32'h0000_0502, 32'h0000_0502, 32'h5A5A_5A5A, 4'h4,  3'b010, 2'd2, 14'h0123, 1, 32'h0,         32'h0000_0123};
        vecs[11] = '{1'b1, 1'b1, 5'd13, 32'h0000_0102, 32'h0000_0102, 32'h0,         4'h0,  3'b001, 2'd1, 14'h0017, 2, 32'hAAAA_F00F, 32'hFFFF_F00F};

        idle_inputs();
        I_rst = 1'b0;
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst busReq",   {31'b0, O_busReq}, 32'd0);
        chk("rst we",       {31'b0, O_we}, 32'd0);
        chk("rst regD",     {27'b0, O_regD}, 32'd0);
        chk("rst wbData",   O_wbData, 32'd0);
        chk("rst busAddr",  O_busAddr, 32'd0);
        chk("rst busWdata", O_busWdata, 32'd0);
        chk("rst busWe",    {28'b0, O_busWe}, 32'd0);
        chk("rst busError", {31'b0, O_busError}, 32'd0);
        I_rst = 1'b1;
        @(posedge I_clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a request is outstanding.
        I_memE = 1'b1; I_we = 1'b1; I_regD = 5'd20; I_memAddress = 32'h0000_0300;
        I_selMem = 3'b000; I_selWb = 2'd1;
        @(posedge I_clk); #1;
        idle_inputs();
        chk("midrst busReq_before", {31'b0, O_busReq}, 32'd1);
        I_rst = 1'b0;
        #1;
        chk("midrst busReq_async", {31'b0, O_busReq}, 32'd0);
        @(posedge I_clk); #1;
        I_busAck = 1'b1;
        I_busRdata = 32'h1234_5678;
        I_rst = 1'b1;
        @(posedge I_clk); #1;
        chk("midrst we_after",     {31'b0, O_we}, 32'd0);
        chk("midrst busReq_after", {31'b0, O_busReq}, 32'd0);
        I_busAck = 1'b0;
        #1;
        chk("midrst stall_idle",   {31'b0, O_stall}, 32'd0);
        @(posedge I_clk); #1;
        chk("midrst we_idle",      {31'b0, O_we}, 32'd0);
        idle_inputs();

`ifdef CEESPU_MEM_TIMEOUT_EN
        // No ack: error pulse and stall release in the fourth REQ cycle.
        I_memE = 1'b1; I_we = 1'b1; I_regD = 5'd21; I_memAddress = 32'h0000_0600;
        I_selWb = 2'd1;
        @(posedge I_clk); #1;
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("tmo busError_c%0d", k), {31'b0, O_busError}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("tmo stall_c%0d", k),    {31'b0, O_stall},    (k == 4) ? 32'd0 : 32'd1);
            chk($sformatf("tmo busReq_c%0d", k),   {31'b0, O_busReq},   32'd1);
            @(posedge I_clk); #1;
        end
        chk("tmo busReq_after",   {31'b0, O_busReq}, 32'd0);
        chk("tmo we_after",       {31'b0, O_we}, 32'd0);
        chk("tmo busError_after", {31'b0, O_busError}, 32'd0);
`else
        // Without the timeout the stage waits as long as the bus takes.
        tv = '{1'b1, 1'b1, 5'd22, 32'h0, 32'h0000_0703, 32'h0, 4'h0, 3'b110, 2'd1, 14'h0020, 20, 32'hA5C3_0000, 32'h0000_00A5};
        run_vec(tv, "longwait");
`endif

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
